wasm_rom_loader: RTL
====================

Name: wasm_rom_loader

Overview:
- Host-side program loader: receives a WebAssembly byte stream over a valid/ready handshake and writes it into the CPU's program ROM (2^ROM_ADDR bytes).
- Holds the CPU in reset until a complete image is loaded, then releases it.
- Validates the 8-byte wasm header (magic + version), strips it, and writes only body bytes from ROM address 0.
- It is the writer side of the program memory that the CPU reads.

Parameters:
- ROM_ADDR, 4, ROM address width; capacity is 2^ROM_ADDR bytes.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- in_data  input  8  stream byte
- in_valid  input  1  in_data valid
- in_last  input  1  marks final byte of image; qualified by in_valid
- in_ready  output  1  loader accepts a byte this cycle
- mem_we  output  1  ROM write strobe
- mem_addr  output  ROM_ADDR  ROM write address
- mem_wdata  output  8  ROM write data
- cpu_reset  output  1  reset to CPU; high until load completes
- done  output  1  image loaded successfully (sticky)
- error  output  3  0 none, 1 bad magic, 2 bad version, 3 overflow, 4 truncated (sticky)
- length  output  ROM_ADDR+1  body bytes written

Behaviour:
- Reset (synchronous, active-high, any state, including mid-load):
  - state=HEADER, hdr_cnt=0, length=0.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - done=0, error=0, cpu_reset=1, in_ready=0 during the reset cycle.
  - ROM contents are not cleared.
- Handshake:
  - A byte is accepted when in_valid && in_ready on a rising edge.
  - in_ready=1 in HEADER and BODY; 0 in DONE and ERROR.
- HEADER:
  - Expected bytes, index 0..7: 00 61 73 6D 01 00 00 00. hdr_cnt counts 0..7.
  - Mismatch at index 0-3 -> ERROR, error=1.
  - Mismatch at index 4-7 -> ERROR, error=2.
  - in_last on index <7 -> ERROR, error=4; the mismatch code takes priority if the byte also mismatches.
  - Matching index 7 with in_last=0 -> BODY.
  - Matching index 7 with in_last=1 -> DONE, length=0.
- BODY, on each accepted byte:
  - If length < 2^ROM_ADDR: next cycle mem_we=1, mem_addr=length[ROM_ADDR-1:0], mem_wdata=byte; length increments. Write latency is 1 cycle; mem_we is a 1-cycle pulse per byte.
  - If length == 2^ROM_ADDR: no write -> ERROR, error=3.
  - in_last on a written byte -> DONE, entered on the same edge that issues the final write.
- DONE:
  - done=1; cpu_reset deasserts 1 cycle after the final mem_we pulse, so the ROM is stable before the CPU fetches.
  - Stays until reset.
- ERROR:
  - error holds its code, done=0, cpu_reset stays 1.
  - Stays until reset; further input is ignored (in_ready=0).
- Invariants:
  - done and error!=0 are never both set.
  - length saturates at 2^ROM_ADDR and never wraps.
  - An in_valid gap (in_valid=0) changes no state.

Optional Feature:
- Macro: WASM_ROM_LOADER_HEADER_CHECK_EN.
- Defined: header validation and stripping as above; error codes 1, 2 and 4 are reachable.
- Undefined:
  - No HEADER state; reset enters BODY and every accepted byte is written from address 0.
  - Only error=3 is reachable.
  - The minimum image is 1 byte, and in_last on it -> DONE with length=1.

Test Plan:
- Valid image, header check on: 00 61 73 6D 01 00 00 00 followed by 42 7D 7E 50 0B with in_last on 0B -> 5 mem_we pulses writing addr0..4 = 42,7D,7E,50,0B; done=1, length=5, error=0; cpu_reset falls 1 cycle after the last write.
- Bad magic: first bytes 00 61 73 6E -> error=1 after the 4th byte, in_ready=0, no mem_we, cpu_reset=1, done=0.
- Overflow with ROM_ADDR=4: valid header plus 17 body bytes -> 16 writes to addr 0..15, then error=3 on the 17th byte; length=16.
- Truncated: 00 61 73 with in_last on 73 -> error=4, no writes.
- Backpressure and reset: random in_valid gaps during the body -> written data is unchanged. Assert reset after the 2nd body byte, then resend the full image -> clean reload, done=1, length correct.
- Macro undefined: stream 05 06 07 with in_last on 07 -> addr0..2 = 05,06,07; done=1, length=3.

Source files
------------

// File: rtl/wasm_rom_loader.sv
// Streams a WebAssembly image into program ROM and holds the CPU in reset until it lands.
// Header validation is enabled by defining WASM_ROM_LOADER_HEADER_CHECK_EN.
module wasm_rom_loader #(
    parameter int ROM_ADDR = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    output logic                mem_we,
    output logic [ROM_ADDR-1:0] mem_addr,
    output logic [7:0]          mem_wdata,
    output logic                cpu_reset,
    output logic                done,
    output logic [2:0]          error,
    output logic [ROM_ADDR:0]   length
);

    typedef enum logic [1:0] {
        S_HEADER,
        S_BODY,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [ROM_ADDR:0] CAP = {1'b1, {ROM_ADDR{1'b0}}};

`ifdef WASM_ROM_LOADER_HEADER_CHECK_EN
    localparam state_t START = S_HEADER;
`else
    localparam state_t START = S_BODY;
`endif

    state_t              state, state_n;
    logic [ROM_ADDR:0]   length_n;
    logic [2:0]          error_n;
    logic                we_n;
    logic [ROM_ADDR-1:0] addr_n;
    logic [7:0]          wdata_n;
    logic                cpu_reset_q, cpu_reset_n;
    logic                accept;

`ifdef WASM_ROM_LOADER_HEADER_CHECK_EN
    logic [2:0] hdr_cnt, hdr_cnt_n;

    function automatic logic [7:0] hdr_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    hdr_byte = 8'h00;
            3'd1:    hdr_byte = 8'h61;
            3'd2:    hdr_byte = 8'h73;
            3'd3:    hdr_byte = 8'h6D;
            3'd4:    hdr_byte = 8'h01;
            default: hdr_byte = 8'h00;
        endcase
    endfunction
`endif

    assign in_ready  = !reset && (state == S_HEADER || state == S_BODY);
    assign accept    = in_valid && in_ready;
    assign done      = !reset && (state == S_DONE);
    assign cpu_reset = reset || cpu_reset_q;

    always_comb begin
        state_n     = state;
        length_n    = length;
        error_n     = error;
        we_n        = 1'b0;
        addr_n      = mem_addr;
        wdata_n     = mem_wdata;
        // Released one cycle after DONE is entered, i.e. after the final write pulse.
        cpu_reset_n = (state != S_DONE);
`ifdef WASM_ROM_LOADER_HEADER_CHECK_EN
        hdr_cnt_n   = hdr_cnt;
`endif
        if (accept) begin
            case (state)
`ifdef WASM_ROM_LOADER_HEADER_CHECK_EN
                S_HEADER: begin
                    if (in_data != hdr_byte(hdr_cnt)) begin
                        state_n = S_ERROR;
                        error_n = hdr_cnt[2] ? 3'd2 : 3'd1;
                    end else if (in_last && hdr_cnt != 3'd7) begin
                        state_n = S_ERROR;
                        error_n = 3'd4;
                    end else if (hdr_cnt == 3'd7) begin
                        state_n = in_last ? S_DONE : S_BODY;
                    end else begin
                        hdr_cnt_n = hdr_cnt + 3'd1;
                    end
                end
`endif
                S_BODY: begin
                    if (length == CAP) begin
                        state_n = S_ERROR;
                        error_n = 3'd3;
                    end else begin
                        we_n     = 1'b1;
                        addr_n   = length[ROM_ADDR-1:0];
                        wdata_n  = in_data;
                        length_n = length + 1'b1;
                        if (in_last) state_n = S_DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= START;
            length      <= '0;
            error       <= 3'd0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= 8'h00;
            cpu_reset_q <= 1'b1;
        end else begin
            state       <= state_n;
            length      <= length_n;
            error       <= error_n;
            mem_we      <= we_n;
            mem_addr    <= addr_n;
            mem_wdata   <= wdata_n;
            cpu_reset_q <= cpu_reset_n;
        end
    end

`ifdef WASM_ROM_LOADER_HEADER_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) hdr_cnt <= 3'd0;
        else       hdr_cnt <= hdr_cnt_n;
    end
`endif

endmodule
